// File: rtl/iig_ctrl_if.sv
// iig_ctrl_if: frame-buffer, iig, classifier and IIGBRAM signals around iig_ctrl (IIG_CTRL_CHECKSUM_EN adds the checksum pair)
interface iig_ctrl_if #(parameter int ADDR_W = 13);
    logic iStart, iHold, iRelease;
    logic oRdreq_to_FB;
    logic [ADDR_W-1:0] oAddr_to_FB;
    logic [7:0] iData_from_FB;
    logic oRun, oInput_ready;
    logic [7:0] oData;
    logic iWrreq_from_IIG;
    logic [ADDR_W-1:0] iAddr_from_IIG;
    logic iCls_rdreq;
    logic [ADDR_W-1:0] iCls_addr;
    logic oCls_grant, oBRAM_wren, oBRAM_rden;
    logic [ADDR_W-1:0] oBRAM_addr;
    logic oBusy, oDone;
`ifdef IIG_CTRL_CHECKSUM_EN
    logic [20:0] iData_from_IIG;
    logic oSum_err;
`endif
    modport master(
        input iStart, iHold, iRelease, iData_from_FB, iWrreq_from_IIG, iAddr_from_IIG, iCls_rdreq, iCls_addr,
        output oRdreq_to_FB, oAddr_to_FB, oRun, oInput_ready, oData, oCls_grant, oBRAM_wren, oBRAM_rden,
        output oBRAM_addr, oBusy, oDone
`ifdef IIG_CTRL_CHECKSUM_EN
        , input iData_from_IIG, output oSum_err
`endif
    );
    modport slave(
        output iStart, iHold, iRelease, iData_from_FB, iWrreq_from_IIG, iAddr_from_IIG, iCls_rdreq, iCls_addr,
        input oRdreq_to_FB, oAddr_to_FB, oRun, oInput_ready, oData, oCls_grant, oBRAM_wren, oBRAM_rden,
        input oBRAM_addr, oBusy, oDone
`ifdef IIG_CTRL_CHECKSUM_EN
        , output iData_from_IIG, input oSum_err
`endif
    );
endinterface

// File: rtl/iig_ctrl.sv
// iig_ctrl: streams a sub-window into iig, counts its IIGBRAM writes, then lends the BRAM port to the classifier
// IIG_CTRL_CHECKSUM_EN: adds a pixel-sum check of iig's final output (iData_from_IIG / oSum_err)
module iig_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int ADDR_W = 13
) (
    input logic iClk,
    input logic iReset,
    iig_ctrl_if.master bus
);
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(IMG_W * IMG_H - 1);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HANDOFF} stateT;
    stateT state, stateNext;
    logic [ADDR_W:0] rdCnt, wrCnt;
    logic inputReady, run, done;
    logic active, rdreq, wr, lastWr, startNow;

    always_ff @(posedge iClk) begin
        if (iReset) state <= IDLE;
        else state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: stateNext = bus.iStart ? LOAD : IDLE;
            LOAD: stateNext = rdreq && rdCnt == LAST ? DRAIN : LOAD;
            DRAIN: stateNext = lastWr ? HANDOFF : DRAIN;
            HANDOFF: stateNext = bus.iRelease ? IDLE : HANDOFF;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        active = state == LOAD || state == DRAIN;
        rdreq = state == LOAD && !bus.iHold;
        wr = active && bus.iWrreq_from_IIG;
        lastWr = state == DRAIN && wr && wrCnt == LAST;
        startNow = state == IDLE && bus.iStart;
        bus.oRdreq_to_FB = rdreq;
        bus.oAddr_to_FB = state == LOAD ? rdCnt[ADDR_W-1:0] : '0;
        bus.oInput_ready = inputReady;
        bus.oData = inputReady ? bus.iData_from_FB : '0;
        bus.oRun = run;
        bus.oDone = done;
        bus.oBusy = state != IDLE;
        bus.oCls_grant = state == HANDOFF;
        bus.oBRAM_wren = wr;
        bus.oBRAM_rden = state == HANDOFF && bus.iCls_rdreq;
        bus.oBRAM_addr = active ? bus.iAddr_from_IIG : state == HANDOFF ? bus.iCls_addr : '0;
    end

    always_ff @(posedge iClk) begin
        if (iReset || startNow) begin
            rdCnt <= '0;
            wrCnt <= '0;
        end else begin
            if (rdreq) rdCnt <= rdCnt + 1'b1;
            if (wr) wrCnt <= wrCnt + 1'b1;
        end
        if (iReset) begin
            inputReady <= 1'b0;
            run <= 1'b0;
            done <= 1'b0;
        end else begin
            inputReady <= rdreq;
            run <= active;
            done <= lastWr;
        end
    end

`ifdef IIG_CTRL_CHECKSUM_EN
    logic [20:0] sum, sumNext;
    logic sumErr;

    // the pixel arriving alongside the final write is still part of the window
    always_comb begin
        sumNext = sum + 21'(bus.oData);
        bus.oSum_err = sumErr;
    end

    always_ff @(posedge iClk) begin
        if (iReset || startNow) begin
            sum <= '0;
            sumErr <= 1'b0;
        end else begin
            sum <= sumNext;
            if (lastWr && bus.iData_from_IIG != sumNext) sumErr <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_iig_ctrl.sv
// tb_iig_ctrl: randomized bench for iig_ctrl; a window-level model of frame buffer, iig and classifier predicts every output
module tb_iig_ctrl;
    localparam int W = 4, H = 4, N = W * H, AW = 13;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0, bad = 0;

    iig_ctrl_if #(.ADDR_W(AW)) bus();
    iig_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (.iClk(clk), .iReset(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [41:0] outs();
        return {bus.oRdreq_to_FB, bus.oAddr_to_FB, bus.oInput_ready, bus.oData, bus.oRun, bus.oBusy, bus.oDone,
                bus.oCls_grant, bus.oBRAM_wren, bus.oBRAM_rden, bus.oBRAM_addr};
    endfunction

    task automatic clear_inputs();
        bus.iStart = 0;
        bus.iHold = 0;
        bus.iRelease = 0;
        bus.iData_from_FB = '0;
        bus.iWrreq_from_IIG = 0;
        bus.iAddr_from_IIG = '0;
        bus.iCls_rdreq = 0;
        bus.iCls_addr = '0;
`ifdef IIG_CTRL_CHECKSUM_EN
        bus.iData_from_IIG = '0;
`endif
    endtask

    // one full window: start, stream, iig writes, done, handoff, release (with a simultaneous ignored start)
    task automatic run_window(input int holdAt, input int holdLen, input int holdPct, input int pix,
                              input int sumDelta, input logic [12:0] clsAddr);
        logic [7:0] fb [N];
        logic [7:0] pix1 = '0;
        logic [14:0] expBram;
        int issued = 0, written = 0, holdLeft = holdLen, addr1 = 0, obsAddr = 0;
        bit hold, expRd, rd1 = 0, del1 = 0, wrNow, expDone = 0, obsRd = 0, lastWr = 0;
`ifdef IIG_CTRL_CHECKSUM_EN
        logic [20:0] sum = '0;
`endif
        for (int i = 0; i < N; i++) fb[i] = pix < 0 ? 8'($urandom) : 8'(pix);
        @(negedge clk);
        clear_inputs();
        bus.iStart = 1;
        bus.iHold = 1'($urandom);
        #1;
        total++;
        if (outs() !== '0) begin bad++; $display("FAIL window_idle got=%h exp=0", outs()); end
        for (int c = 1; !expDone; c++) begin
            @(negedge clk);
            bus.iStart = 0;
            hold = issued == holdAt && holdLeft > 0 ? 1'b1 : $urandom_range(99) < holdPct;
            if (issued == holdAt && holdLeft > 0) holdLeft--;
            wrNow = del1;
            bus.iHold = hold;
            bus.iData_from_FB = obsRd ? fb[obsAddr] : 8'($urandom);
            bus.iWrreq_from_IIG = wrNow;
            bus.iAddr_from_IIG = wrNow ? 13'(written) : 13'($urandom);
`ifdef IIG_CTRL_CHECKSUM_EN
            if (wrNow) sum += 21'(pix1);
            bus.iData_from_IIG = wrNow && written == N - 1 ? 21'(int'(sum) + sumDelta) : sum;
`endif
            bus.iCls_rdreq = 1'($urandom);
            bus.iCls_addr = 13'($urandom);
            expRd = issued < N && !hold;
            expDone = lastWr;
            #1;
            total++;
            if ({bus.oRdreq_to_FB, expRd ? bus.oAddr_to_FB : 13'd0} !== {expRd, expRd ? 13'(issued) : 13'd0}) begin
                bad++;
                $display("FAIL fb_read cyc=%0d got rdreq=%b addr=%0d exp rdreq=%b addr=%0d",
                         c, bus.oRdreq_to_FB, bus.oAddr_to_FB, expRd, issued);
            end
            total++;
            if ({bus.oInput_ready, bus.oData} !== {rd1, rd1 ? fb[addr1] : 8'd0}) begin
                bad++;
                $display("FAIL pixel cyc=%0d got ready=%b data=%h exp ready=%b data=%h",
                         c, bus.oInput_ready, bus.oData, rd1, rd1 ? fb[addr1] : 8'd0);
            end
            expBram = expDone ? {1'b0, bus.iCls_rdreq, bus.iCls_addr} : {wrNow, 1'b0, bus.iAddr_from_IIG};
            total++;
            if ({bus.oBRAM_wren, bus.oBRAM_rden, bus.oBRAM_addr} !== expBram) begin
                bad++;
                $display("FAIL bram_mux cyc=%0d got wren/rden/addr=%h exp=%h",
                         c, {bus.oBRAM_wren, bus.oBRAM_rden, bus.oBRAM_addr}, expBram);
            end
            total++;
            if ({bus.oRun, bus.oBusy, bus.oDone, bus.oCls_grant} !== {c >= 2, 1'b1, expDone, expDone}) begin
                bad++;
                $display("FAIL status cyc=%0d got run/busy/done/grant=%b exp=%b",
                         c, {bus.oRun, bus.oBusy, bus.oDone, bus.oCls_grant}, {c >= 2, 1'b1, expDone, expDone});
            end
`ifdef IIG_CTRL_CHECKSUM_EN
            total++;
            if (bus.oSum_err !== (expDone && sumDelta != 0)) begin
                bad++;
                $display("FAIL sum_err cyc=%0d got=%b exp=%b", c, bus.oSum_err, expDone && sumDelta != 0);
            end
`endif
            obsRd = bus.oRdreq_to_FB;
            obsAddr = int'(bus.oAddr_to_FB);
            del1 = rd1;
            pix1 = fb[addr1];
            rd1 = expRd;
            addr1 = issued;
            if (expRd) issued++;
            if (wrNow) written++;
            lastWr = wrNow && written == N;
        end
        @(negedge clk);
        clear_inputs();
        bus.iCls_addr = clsAddr;
        bus.iCls_rdreq = 1;
        bus.iWrreq_from_IIG = 1;
        bus.iAddr_from_IIG = 13'($urandom);
        bus.iRelease = 1;
        bus.iStart = 1;
        #1;
        total++;
        if ({bus.oCls_grant, bus.oBusy, bus.oRun, bus.oDone, bus.oRdreq_to_FB, bus.oBRAM_wren, bus.oBRAM_rden,
             bus.oBRAM_addr} !== {6'b110000, 1'b1, clsAddr}) begin
            bad++;
            $display("FAIL handoff got grant/busy/run/done/rdreq/wren/rden/addr=%h exp=%h",
                     {bus.oCls_grant, bus.oBusy, bus.oRun, bus.oDone, bus.oRdreq_to_FB, bus.oBRAM_wren,
                      bus.oBRAM_rden, bus.oBRAM_addr}, {6'b110000, 1'b1, clsAddr});
        end
        @(negedge clk);
        bus.iRelease = 0;
        bus.iStart = 0;
        #1;
        total++;
        if (outs() !== '0) begin bad++; $display("FAIL release_idle got=%h exp=0", outs()); end
`ifdef IIG_CTRL_CHECKSUM_EN
        total++;
        if (bus.oSum_err !== (sumDelta != 0)) begin
            bad++;
            $display("FAIL sum_err_held got=%b exp=%b", bus.oSum_err, sumDelta != 0);
        end
`endif
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        bus.iData_from_FB = 8'hA5;
        bus.iAddr_from_IIG = 13'h0ABC;
        bus.iCls_addr = 13'h1234;
        bus.iWrreq_from_IIG = 1;
        bus.iCls_rdreq = 1;
        bus.iStart = 1;
        #1;
        total++;
        if (outs() !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", outs()); end
`ifdef IIG_CTRL_CHECKSUM_EN
        total++;
        if (bus.oSum_err !== 1'b0) begin bad++; $display("FAIL reset_sum_err got=%b exp=0", bus.oSum_err); end
`endif
        @(negedge clk);
        rst = 0;
        bus.iStart = 0;
        #1;
        total++;
        if (outs() !== '0) begin bad++; $display("FAIL reset_start_ignored got=%h exp=0", outs()); end
    endtask

    task automatic test_idle_protection();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clear_inputs();
            bus.iWrreq_from_IIG = 1;
            bus.iAddr_from_IIG = 13'($urandom);
            bus.iCls_rdreq = 1;
            bus.iCls_addr = 13'($urandom);
            bus.iHold = 1'($urandom);
            bus.iData_from_FB = 8'($urandom);
            #1;
            total++;
            if (outs() !== '0) begin bad++; $display("FAIL idle_protect i=%0d got=%h exp=0", i, outs()); end
        end
    endtask

    task automatic test_basic();
        run_window(-1, 0, 0, -1, 0, 13'h005);
    endtask

    task automatic test_hold();
        run_window(7, 3, 0, -1, 0, 13'($urandom));
    endtask

    task automatic test_final_hold();
        run_window(N - 1, 2, 0, -1, 0, 13'($urandom));
    endtask

    task automatic test_random();
        repeat (4) run_window(-1, 0, 30, -1, 0, 13'($urandom));
    endtask

    task automatic test_midreset();
        @(negedge clk);
        clear_inputs();
        bus.iStart = 1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.iStart = 0;
            bus.iData_from_FB = 8'($urandom);
            bus.iWrreq_from_IIG = c > 2;
            bus.iAddr_from_IIG = 13'(c);
            if (c == 10) begin
                rst = 1;
                #1;
                total++;
                if ({bus.oRdreq_to_FB, bus.oAddr_to_FB} !== {1'b1, 13'd9}) begin
                    bad++;
                    $display("FAIL midreset_addr got rdreq=%b addr=%0d exp rdreq=1 addr=9",
                             bus.oRdreq_to_FB, bus.oAddr_to_FB);
                end
            end
        end
        @(negedge clk);
        rst = 0;
        bus.iWrreq_from_IIG = 1;
        bus.iCls_rdreq = 1;
        bus.iData_from_FB = 8'h5A;
        #1;
        total++;
        if (outs() !== '0) begin bad++; $display("FAIL midreset_outputs got=%h exp=0", outs()); end
        run_window(-1, 0, 0, -1, 0, 13'h0F0);
    endtask

    task automatic test_checksum();
        run_window(-1, 0, 0, 255, 0, 13'h011);
        run_window(-1, 0, 20, 255, -1, 13'h012);
        run_window(-1, 0, 0, -1, 0, 13'h013);
    endtask

    initial begin
        test_reset();
        test_idle_protection();
        test_basic();
        test_hold();
        test_final_hold();
        test_random();
        test_midreset();
        test_checksum();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iig_ctrl.md
Name: iig_ctrl

Overview:
Sequencer and BRAM-port owner for the integral image generator (pre_iig via iig) and the integral image BRAM (IIGBRAM).
- On iStart: streams one IMG_W x IMG_H grey sub-window (8-bit) from the frame buffer into the generator.
- Counts the generator's BRAM writes until the integral image is complete.
- Then grants the single IIGBRAM port to the classifier until it releases it.
- Sits between frame buffer, iig, IIGBRAM and classifier in the detection pipeline.

Parameters:
- IMG_W, 64, sub-window width in pixels.
- IMG_H, 64, sub-window height in pixels. IMG_W*IMG_H must be <= 2^ADDR_W, and 255*IMG_W*IMG_H must be < 2^21.
- ADDR_W, 13, frame-buffer and IIGBRAM address width.

Ports:
- iClk  in  1  single system clock, all logic on rising edge.
- iReset  in  1  synchronous, active-high reset.
- iStart  in  1  one-cycle pulse; begins a window, honoured in IDLE only.
- iHold  in  1  stall; while high, no new frame-buffer read is issued.
- oRdreq_to_FB  out  1  frame-buffer read strobe.
- oAddr_to_FB  out  ADDR_W  frame-buffer read address, row-major 0..N-1 (N=IMG_W*IMG_H).
- iData_from_FB  in  8  pixel; valid exactly 1 cycle after oRdreq_to_FB.
- oRun  out  1  to iig iRun.
- oInput_ready  out  1  to iig iInput_ready.
- oData  out  8  to iig iData.
- iWrreq_from_IIG  in  1  iig oWrreq_to_IIGBRAM.
- iAddr_from_IIG  in  13  iig oAddr_to_IIGBRAM.
- iCls_rdreq  in  1  classifier read request.
- iCls_addr  in  13  classifier read address.
- iRelease  in  1  one-cycle pulse; classifier is finished with the BRAM.
- oCls_grant  out  1  classifier owns IIGBRAM.
- oBRAM_wren  out  1  IIGBRAM write enable.
- oBRAM_rden  out  1  IIGBRAM read enable.
- oBRAM_addr  out  13  IIGBRAM address.
- oBusy  out  1  high in any state other than IDLE.
- oDone  out  1  one-cycle pulse when the integral image is complete.

Behaviour:
- Reset (synchronous, iReset=1 at a clock edge):
  - State goes to IDLE and all counters clear.
  - All outputs are 0, including every address and oData.
  - Reset mid-operation aborts immediately; no further FB reads or BRAM writes are issued from the next cycle.
- States: IDLE, LOAD, DRAIN, HANDOFF.
- IDLE:
  - iStart=1 -> LOAD; read counter rd_cnt=0, write counter wr_cnt=0.
  - iStart in any other state is ignored.
- LOAD:
  - Each cycle with iHold=0: oRdreq_to_FB=1, oAddr_to_FB=rd_cnt, rd_cnt++.
  - With iHold=1: oRdreq_to_FB=0 and rd_cnt holds.
  - When the read at rd_cnt=N-1 issues -> DRAIN.
- Pixel path:
  - oInput_ready is oRdreq_to_FB delayed by exactly 1 cycle (registered).
  - oData = iData_from_FB (combinational) while oInput_ready=1; otherwise 0.
  - Minimum latency start->first pixel: iStart at cycle t, rdreq at t+1, oInput_ready at t+2.
- oRun is registered:
  - Goes 1 the cycle after entering LOAD.
  - Stays 1 through DRAIN.
  - Goes 0 the cycle after leaving DRAIN.
- Write counting (LOAD and DRAIN): each iWrreq_from_IIG=1 increments wr_cnt.
- DRAIN: when a write occurs with wr_cnt=N-1 -> HANDOFF, with oDone=1 for that transition cycle+1 (single pulse).
- HANDOFF: oCls_grant=1; iRelease=1 -> IDLE.
- BRAM mux (combinational on state):
  - LOAD/DRAIN: oBRAM_addr=iAddr_from_IIG, oBRAM_wren=iWrreq_from_IIG, oBRAM_rden=0.
  - HANDOFF: oBRAM_addr=iCls_addr, oBRAM_rden=iCls_rdreq, oBRAM_wren=0.
  - IDLE: all 0.
- Protection:
  - iig writes in IDLE/HANDOFF are blocked and not counted.
  - Classifier requests outside HANDOFF are blocked.
- Simultaneous events:
  - iRelease and iStart in the same HANDOFF cycle: release is taken, start is ignored.
  - iHold during the final read: the read is deferred, and DRAIN is entered only after it issues.
- Counter widths: ADDR_W+1 bits, with no wrap during a legal window.

Optional Feature:
IIG_CTRL_CHECKSUM_EN
- Defined:
  - Adds port iData_from_IIG in 21 (iig oData) and port oSum_err out 1.
  - Accumulates a 21-bit sum of every pixel delivered with oInput_ready=1.
  - On the final counted write, compares iData_from_IIG against the sum.
  - oSum_err is registered: set in the oDone cycle on mismatch, held until the next iStart or reset.
- Undefined: neither port exists, there is no accumulator, and behaviour is otherwise identical.

Test Plan:
- Reset, then iStart, IMG_W=IMG_H=4 (N=16), iHold=0 -> rdreq addresses 0..15 on 16 consecutive cycles; oInput_ready mirrors them 1 cycle later; oRun=1; oBusy=1.
- iig model issues 16 writes -> oDone pulses once after the 16th write; oCls_grant=1; oBRAM_addr follows iCls_addr=0x05 with oBRAM_rden=1.
- iHold=1 for 3 cycles at rd_cnt=7 -> no rdreq during the hold; address 7 is issued on resume; 16 reads total.
- Inject iWrreq_from_IIG in IDLE and iCls_rdreq during LOAD -> oBRAM_wren=0 and oBRAM_rden=0; wr_cnt is unchanged.
- iReset=1 mid-LOAD at rd_cnt=9 -> next cycle all outputs 0 and state IDLE; a fresh iStart restarts at address 0.
- With IIG_CTRL_CHECKSUM_EN: all pixels 0xFF, final iData_from_IIG=4080 -> oSum_err=0; final value 4079 -> oSum_err=1.
